// File: rtl/lfsr_rng_gen_pkg.sv
// lfsr_pkg: shared types and constants for the LFSR random-number generator.
//   gather_state_e  : word-gathering FSM states (COLLECT, FULL)
//   TAPS_W*         : primitive Fibonacci feedback masks for common widths
package lfsr_pkg;

  typedef enum logic {
    COLLECT = 1'b0,  // shifting feedback bits into the collector
    FULL    = 1'b1   // collector holds a finished word waiting for the output reg
  } gather_state_e;

  // Maximal-length feedback masks, fb = ^(state & TAPS).
  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_rng_gen_if.sv
// lfsr_rng_gen_if: valid/ready stream carrying gathered random words.
//   rnd_data  : OUT_BITS-wide random word
//   rnd_valid : rnd_data holds an unconsumed word
//   rnd_ready : consumer accepts the word when rnd_valid && rnd_ready
// master = producer (the generator), slave = consumer.
interface lfsr_rng_gen_if #(
  parameter int OUT_BITS = 4
);
  logic [OUT_BITS-1:0] rnd_data;
  logic                rnd_valid;
  logic                rnd_ready;

  modport master (output rnd_data, output rnd_valid, input  rnd_ready);
  modport slave  (input  rnd_data, input  rnd_valid, output rnd_ready);
endinterface

// File: rtl/lfsr_rng_gen_onehot_dec.sv
// lfsr_onehot_dec: combinational binary-to-one-hot decoder.
//   sel    in  SEL_BITS       index to decode
//   onehot out 2**SEL_BITS    1 << sel
module lfsr_onehot_dec #(
  parameter int SEL_BITS = 3
) (
  input  logic [SEL_BITS-1:0]      sel,
  output logic [2**SEL_BITS-1:0]   onehot
);
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen: parametrised Fibonacci LFSR random-number generator.
//   clk, reset      clock (rising edge), async active-high reset
//   enable          advance the LFSR one step per cycle
//   seed_load/seed  load a seed (zero is replaced by RESET_SEED); beats enable
//   lfsr_out        current LFSR state
//   rnd (master)    OUT_BITS-wide words of gathered feedback bits, valid/ready
//   onehot_out      1 << state[SEL_BITS-1:0]
//   seed_rejected   one-cycle pulse when a zero seed was substituted
// Legal ranges: WIDTH 3..32, OUT_BITS 2..WIDTH, SEL_BITS <= WIDTH,
// RESET_SEED nonzero.
module lfsr_rng_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = TAPS_W4,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'h1,
  parameter int               OUT_BITS   = 4,
  parameter int               SEL_BITS   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   seed_load,
  input  logic [WIDTH-1:0]       seed,
  output logic [WIDTH-1:0]       lfsr_out,
  lfsr_rng_gen_if.master         rnd,
  output logic [2**SEL_BITS-1:0] onehot_out,
  output logic                   seed_rejected
);

  localparam int            CW   = $clog2(OUT_BITS);
  localparam logic [CW-1:0] LAST = CW'(OUT_BITS - 1);

  logic [WIDTH-1:0]    state;
  logic                fb;
  logic                step;
  logic                out_free;
  logic [OUT_BITS-1:0] col;
  logic [OUT_BITS-1:0] word;
  logic [CW-1:0]       count;
  gather_state_e       fsm;
  logic [OUT_BITS-1:0] rnd_data_q;
  logic                rnd_valid_q;

  assign fb       = ^(state & TAPS);
  assign step     = enable && !seed_load;
  // Output register can take a new word this edge: empty or being drained.
  assign out_free = !rnd_valid_q || rnd.rnd_ready;
  // Collector after shifting in this cycle's feedback bit; first bit lands at MSB.
  assign word     = {col[OUT_BITS-2:0], fb};

  // LFSR state and seed handling. Loads never leave the state at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RESET_SEED;
      seed_rejected <= 1'b0;
    end else if (seed_load) begin
      state         <= (seed == '0) ? RESET_SEED : seed;
      seed_rejected <= (seed == '0);
    end else begin
      seed_rejected <= 1'b0;
      if (enable) state <= {state[WIDTH-2:0], fb};
    end
  end

  // Word-gathering FSM with one word of buffering in the collector (FULL).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm         <= COLLECT;
      col         <= '0;
      count       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
    end else if (seed_load) begin
      // Seed load restarts gathering and drops any pending word.
      fsm         <= COLLECT;
      col         <= '0;
      count       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      // Drained with nothing new: later assignments below override this.
      if (rnd_valid_q && rnd.rnd_ready) rnd_valid_q <= 1'b0;
      case (fsm)
        COLLECT: begin
          if (step) begin
            if (count == LAST) begin
              count <= '0;
              if (out_free) begin
                rnd_data_q  <= word;
                rnd_valid_q <= 1'b1;
                col         <= '0;
              end else begin
                col <= word;
                fsm <= FULL;
              end
            end else begin
              col   <= word;
              count <= count + 1'b1;
            end
          end
        end
        FULL: begin
          // Bits produced by LFSR steps here are not gathered.
          if (out_free) begin
            rnd_data_q  <= col;
            rnd_valid_q <= 1'b1;
            col         <= '0;
            count       <= '0;
            fsm         <= COLLECT;
          end
        end
        default: fsm <= COLLECT;
      endcase
    end
  end

  assign lfsr_out      = state;
  assign rnd.rnd_data  = rnd_data_q;
  assign rnd.rnd_valid = rnd_valid_q;

  lfsr_onehot_dec #(.SEL_BITS(SEL_BITS)) u_dec (
    .sel    (state[SEL_BITS-1:0]),
    .onehot (onehot_out)
  );

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Self-checking bench for lfsr_rng_gen at default parameters: directed steps
// from the test plan plus a randomized phase, all compared against a
// bit-queue reference model of the generator.
module tb_lfsr_rng_gen;
  localparam int WIDTH = 4;
  localparam int OB    = 4;
  localparam int TAPS  = 'hC;
  localparam int RSEED = 1;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             seed_load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [WIDTH-1:0] lfsr_out;
  logic [7:0]       onehot_out;
  logic             seed_rejected;

  lfsr_rng_gen_if #(.OUT_BITS(OB)) rif ();

  lfsr_rng_gen dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .seed_load     (seed_load),
    .seed          (seed),
    .lfsr_out      (lfsr_out),
    .rnd           (rif),
    .onehot_out    (onehot_out),
    .seed_rejected (seed_rejected)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: state as an integer, partial word as a queue of bits,
  // one held word, output register.
  int m_state;
  bit pbits[$];
  int held;
  bit held_v;
  int m_data;
  bit m_valid;
  bit m_rej;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = RSEED; pbits.delete(); held = 0; held_v = 0;
    m_data = 0; m_valid = 0; m_rej = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lfsr"},   32'(lfsr_out),      32'(m_state));
    chk({tag, ".onehot"}, 32'(onehot_out),    32'(1 << (m_state % 8)));
    chk({tag, ".valid"},  32'(rif.rnd_valid), 32'(m_valid));
    chk({tag, ".data"},   32'(rif.rnd_data),  32'(m_data));
    chk({tag, ".rej"},    32'(seed_rejected), 32'(m_rej));
  endtask

  // Apply the current inputs for one clock edge to the model, then compare.
  task automatic step(input string tag);
    int  fb, w, nv;
    bit  free;
    fb   = $countones(m_state & TAPS) % 2;
    free = !m_valid || (rif.rnd_ready === 1'b1);
    if (seed_load) begin
      m_rej   = (seed == 0);
      m_state = (seed == 0) ? RSEED : int'(seed);
      pbits.delete(); held_v = 0; m_valid = 0;
    end else begin
      m_rej = 0;
      nv = (m_valid && !rif.rnd_ready) ? 1 : 0;
      if (held_v) begin
        if (free) begin m_data = held; nv = 1; held_v = 0; end
      end else if (enable) begin
        pbits.push_back(fb[0]);
        if (pbits.size() == OB) begin
          w = 0;
          foreach (pbits[i]) w = (w << 1) | int'(pbits[i]);
          pbits.delete();
          if (free) begin m_data = w; nv = 1; end
          else begin held = w; held_v = 1; end
        end
      end
      m_valid = nv[0];
      if (enable) m_state = ((m_state << 1) | fb) & MASK;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Assert reset between edges and check outputs before any edge occurs.
  task automatic do_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst.lfsr",   32'(lfsr_out),      32'h1);
    chk("rst.onehot", 32'(onehot_out),    32'h02);
    chk("rst.valid",  32'(rif.rnd_valid), 32'h0);
    chk("rst.data",   32'(rif.rnd_data),  32'h0);
    chk("rst.rej",    32'(seed_rejected), 32'h0);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    rif.rnd_ready = 1'b0;
    model_reset();

    // Reset state before any clock edge.
    #3;
    do_reset();

    // Free-running sequence, consumer always ready.
    enable = 1'b1; rif.rnd_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step("run");
      chk("seq", 32'(lfsr_out), 32'(seq[k % 15]));
      if (k == 4) begin
        chk("word1.valid", 32'(rif.rnd_valid), 32'h1);
        chk("word1.data",  32'(rif.rnd_data),  32'h3);
      end
      if (k == 5) chk("word1.drop", 32'(rif.rnd_valid), 32'h0);
      if (k == 8) chk("word2.data", 32'(rif.rnd_data), 32'h5);
    end

    // Consumer stalls 20 cycles: first word held, second parked in FULL.
    do_reset();
    rif.rnd_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step("stall");
      if (k >= 4) chk("stall.data", 32'(rif.rnd_data), 32'h3);
    end
    chk("stall.lfsr", 32'(lfsr_out), 32'(seq[20 % 15]));
    rif.rnd_ready = 1'b1;
    step("drain1");
    chk("drain1.data", 32'(rif.rnd_data), 32'h5);
    step("drain2");

    // Zero seed is rejected and replaced; nonzero seed loads as-is.
    seed_load = 1'b1; seed = '0;
    step("seed0");
    chk("seed0.rej", 32'(seed_rejected), 32'h1);
    seed_load = 1'b0;
    step("seed0.after");
    seed_load = 1'b1; seed = 4'h9;
    step("seed9");
    chk("seed9.lfsr", 32'(lfsr_out), 32'h9);
    seed_load = 1'b0;

    // Enable low for 5 cycles mid-word.
    step("pre_hold");
    step("pre_hold");
    enable = 1'b0;
    for (int k = 0; k < 5; k++) step("hold");
    enable = 1'b1;
    for (int k = 0; k < 6; k++) step("resume");

    // Seed load during a handshake with enable high: word dropped, no step.
    rif.rnd_ready = 1'b0;
    for (int k = 0; k < 4; k++) step("prep");
    rif.rnd_ready = 1'b1; seed_load = 1'b1; seed = 4'h6;
    step("load_hs");
    chk("load_hs.valid", 32'(rif.rnd_valid), 32'h0);
    chk("load_hs.lfsr",  32'(lfsr_out),      32'h6);
    seed_load = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      enable        = ($urandom_range(0, 9) < 8);
      rif.rnd_ready = ($urandom_range(0, 2) != 0);
      seed_load     = ($urandom_range(0, 29) == 0);
      seed          = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step("rand");
    end
    seed_load = 1'b0;

    // Reach FULL, then reset asynchronously mid-word.
    do_reset();
    enable = 1'b1; rif.rnd_ready = 1'b0;
    for (int k = 0; k < 10; k++) step("tofull");
    do_reset();
    enable = 1'b1; rif.rnd_ready = 1'b1;
    for (int k = 0; k < 4; k++) step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
